// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: forwarding-mux select encoding, hazard FSM states
// and the hardwired-zero register index.
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_select.sv
// Priority match of one source register against the three in-flight producers;
// the youngest writer wins and register 0 never forwards.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  ex_reg_write,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output fwd_sel_t              sel
);

  logic rs_nonzero;
  assign rs_nonzero = (rs != REG_ADDR_W'(REG_ZERO));

  // NOTE: sel gets a default before the priority chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = FWD_RF;
    if (rs_nonzero && ex_reg_write && (ex_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (rs_nonzero && mem_reg_write && (mem_rd == rs)) begin
      sel = FWD_MEMWB;
    end else if (rs_nonzero && wb_reg_write && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller: registered operand-forwarding selects plus load-use stall
// and taken-branch flush FSM. Define HAZARD_PERF_EN to build the perf counters.
module hazard_forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  ex_reg_write,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
);

  localparam logic [2:0] LAT_RELOAD = 3'(LOAD_LAT - 1);

  hz_state_t state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       load_use;
  logic       stall_raw, flush_if_id_raw, flush_id_ex_raw;
  fwd_sel_t   sel_a_next, sel_b_next, sel_a_q, sel_b_q;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(id_rs1), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .sel(sel_a_next)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(id_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .sel(sel_b_next)
  );

  assign load_use = id_valid && ex_mem_read && ex_reg_write
                    && (ex_rd != REG_ADDR_W'(REG_ZERO))
                    && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    stall_raw       = 1'b0;
    flush_if_id_raw = 1'b0;
    flush_id_ex_raw = 1'b0;
    if (branch_taken) begin
      // The stalled instruction is squashed anyway, so the branch wins.
      flush_if_id_raw = 1'b1;
      flush_id_ex_raw = 1'b1;
      state_next      = HZ_RUN;
      cnt_next        = '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (load_use) begin
            stall_raw       = 1'b1;
            flush_id_ex_raw = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_next   = LAT_RELOAD;
              state_next = HZ_STALL;
            end
          end
        end
        HZ_STALL: begin
          stall_raw       = 1'b1;
          flush_id_ex_raw = 1'b1;
          cnt_next        = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_next = HZ_RUN;
          end
        end
        default: begin
          state_next = HZ_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Gate with rst_n so a reset landing mid-stall drops every control at once.
  assign stall_if    = stall_raw && rst_n;
  assign stall_id    = stall_raw && rst_n;
  assign flush_if_id = flush_if_id_raw && rst_n;
  assign flush_id_ex = flush_id_ex_raw && rst_n;

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: the select registers are reset explicitly because EX consumes them
  // as mux controls in the very first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else if (flush_id_ex_raw) begin
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else if (!stall_raw) begin
      sel_a_q <= sel_a_next;
      sel_b_q <= sel_b_next;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_raw && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_if_id_raw && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and
// are compared each cycle against a behavioural stall/forward model.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read, branch_taken;

  logic [1:0]  fa[2], fb[2];
  logic        sif[2], sid[2], fi[2], fe[2];
  logic [15:0] sc[2], fc[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_ADDR_W(4), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_reg_write(ex_reg_write),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .stall_if(sif[0]), .stall_id(sid[0]),
    .flush_if_id(fi[0]), .flush_id_ex(fe[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
  );

  hazard_forward_unit #(.REG_ADDR_W(4), .LOAD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_reg_write(ex_reg_write),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .stall_if(sif[1]), .stall_id(sid[1]),
    .flush_if_id(fi[1]), .flush_id_ex(fe[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
  );

  // Reference model state: remaining extra stall cycles, held selects, counts.
  int         lat[2] = '{1, 3};
  int         rem[2];
  logic [1:0] msel_a[2], msel_b[2];
  int         mscnt[2], mfcnt[2];
  logic       est[2], efi[2], efe[2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [3:0] rs);
    if (rs == 4'd0) return 2'd0;
    if (ex_reg_write && ex_rd == rs) return 2'd1;
    if (mem_reg_write && mem_rd == rs) return 2'd2;
    if (wb_reg_write && wb_rd == rs) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef HAZARD_PERF_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n >= 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_mem_read = 0; branch_taken = 0;
  endtask

  // One clock: check mid-cycle against the model, then advance the model.
  task automatic step();
    logic lu;
    @(negedge clk);
    lu = id_valid && ex_mem_read && ex_reg_write && ex_rd != 0
         && (ex_rd == id_rs1 || ex_rd == id_rs2);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rem[k] = 0; msel_a[k] = 0; msel_b[k] = 0; mscnt[k] = 0; mfcnt[k] = 0;
        est[k] = 0; efi[k] = 0; efe[k] = 0;
      end else if (branch_taken) begin
        est[k] = 0; efi[k] = 1; efe[k] = 1;
      end else begin
        est[k] = (rem[k] > 0) || lu; efi[k] = 0; efe[k] = est[k];
      end
      check($sformatf("stall_if[%0d]", k), 16'(sif[k]), 16'(est[k]));
      check($sformatf("stall_id[%0d]", k), 16'(sid[k]), 16'(est[k]));
      check($sformatf("flush_if_id[%0d]", k), 16'(fi[k]), 16'(efi[k]));
      check($sformatf("flush_id_ex[%0d]", k), 16'(fe[k]), 16'(efe[k]));
      check($sformatf("fwd_a_sel[%0d]", k), 16'(fa[k]), 16'(msel_a[k]));
      check($sformatf("fwd_b_sel[%0d]", k), 16'(fb[k]), 16'(msel_b[k]));
      check($sformatf("stall_cnt[%0d]", k), sc[k], exp_cnt(mscnt[k]));
      check($sformatf("flush_cnt[%0d]", k), fc[k], exp_cnt(mfcnt[k]));
    end
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (efe[k]) begin
          msel_a[k] = 0; msel_b[k] = 0;
        end else if (!est[k]) begin
          msel_a[k] = ref_sel(id_rs1); msel_b[k] = ref_sel(id_rs2);
        end
        if (branch_taken) rem[k] = 0;
        else if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (lu) rem[k] = lat[k] - 1;
        mscnt[k] += int'(est[k]);
        mfcnt[k] += int'(efi[k]);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic load_r5_in_ex();
    set_idle();
    id_valid = 1; id_rs1 = 5; ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
  endtask

  task automatic load_moved_to_mem();
    set_idle();
    id_valid = 1; id_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
  endtask

  initial begin
    int stall_seen;
    rst_n = 0;
    set_idle();
    #1;
    check("reset_sel_a", 16'(fa[0]), 16'd0);
    check("reset_stall", 16'(sid[1]), 16'd0);
    do_reset();

    // Forwarding priority
    set_idle(); id_valid = 1; id_rs1 = 3;
    ex_rd = 3; ex_reg_write = 1; mem_rd = 3; mem_reg_write = 1;
    step(); check("prio_ex", 16'(fa[0]), 16'd1);
    ex_reg_write = 0;
    step(); check("prio_mem", 16'(fa[0]), 16'd2);
    mem_reg_write = 0; wb_rd = 3; wb_reg_write = 1;
    step(); check("prio_wb", 16'(fa[0]), 16'd3);

    // R0 exclusion (preceded by a nonzero select on operand B)
    set_idle(); id_valid = 1; id_rs2 = 3; wb_rd = 3; wb_reg_write = 1;
    step(); check("r0_pre", 16'(fb[0]), 16'd3);
    set_idle(); id_valid = 1; id_rs2 = 0; ex_rd = 0; ex_reg_write = 1; ex_mem_read = 1;
    #1 check("r0_nostall", 16'(sid[0]), 16'd0);
    step(); check("r0_sel", 16'(fb[0]), 16'd0);

    // Load-use, LOAD_LAT = 1
    do_reset();
    load_r5_in_ex();
    #1;
    check("lu1_stall_if", 16'(sif[0]), 16'd1);
    check("lu1_flush_id_ex", 16'(fe[0]), 16'd1);
    step();
    load_moved_to_mem();
    #1 check("lu1_release", 16'(sid[0]), 16'd0);
    step(); check("lu1_fwd_mem", 16'(fa[0]), 16'd2);

    // Load-use, LOAD_LAT = 3: exactly three stall cycles
    do_reset();
    load_r5_in_ex();
    stall_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1 stall_seen += int'(sid[1]);
      step();
      load_moved_to_mem();
    end
    check("lu3_len", 16'(stall_seen), 16'd3);
`ifdef HAZARD_PERF_EN
    check("lu3_stall_cnt", sc[1], 16'd3);
`else
    check("lu3_stall_cnt", sc[1], 16'd0);
`endif

    // Branch during the 2nd stall cycle of LOAD_LAT = 3
    do_reset();
    load_r5_in_ex();
    step();
    branch_taken = 1;
    #1;
    check("br_flush_if_id", 16'(fi[1]), 16'd1);
    check("br_flush_id_ex", 16'(fe[1]), 16'd1);
    check("br_stall", 16'(sid[1]), 16'd0);
    step();
    set_idle();
    #1;
    check("br_run", 16'(sid[1]), 16'd0);
    check("br_sel", 16'(fa[1]), 16'd0);
    step();

    // Reset in the 2nd stall cycle with the load-use inputs still present
    do_reset();
    load_r5_in_ex();
    step();
    rst_n = 0;
    #1;
    check("rst_stall", 16'(sid[1]), 16'd0);
    check("rst_flush", 16'(fe[1]), 16'd0);
    check("rst_sel", 16'(fa[1]), 16'd0);
    step();
    rst_n = 1;
    set_idle();
    step(); check("rst_resume0", 16'(fa[1]), 16'd0);
    id_valid = 1; id_rs1 = 3; mem_rd = 3; mem_reg_write = 1;
    step(); check("rst_resume_fwd", 16'(fa[1]), 16'd2);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = 4'($urandom_range(0, 3));
      id_rs2        = 4'($urandom_range(0, 3));
      ex_rd         = 4'($urandom_range(0, 3));
      mem_rd        = 4'($urandom_range(0, 3));
      wb_rd         = 4'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller that drives the 2-bit `select` inputs of the two operand-forwarding `mux_4` instances in EX. It also generates stall and flush controls for IF/ID and ID/EX. Each cycle it compares the source registers of the instruction in ID against the destinations of the three older in-flight instructions. It registers the forwarding selects into the ID/EX boundary, and runs a small FSM for load-use stalls and taken-branch flushes. Datapath width is 16 bits; this block carries control only.

## Interface
Parameters:
- `REG_ADDR_W`, 4: register index width (16 architectural registers).
- `LOAD_LAT`, 1: load-use stall length in cycles, 1..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  sources of the ID instruction.
- `ex_rd`, `mem_rd`, `wb_rd`  in  REG_ADDR_W  destinations in EX, MEM, WB.
- `ex_reg_write`, `mem_reg_write`, `wb_reg_write`  in  1  per-stage write enables.
- `ex_mem_read`  in  1  EX instruction is a load.
- `branch_taken`  in  1  branch resolved taken in EX.
- `fwd_a_sel`, `fwd_b_sel`  out  2  registered `mux_4` selects for operands A and B.
- `stall_if`, `stall_id`  out  1  hold PC and IF/ID.
- `flush_if_id`, `flush_id_ex`  out  1  insert a bubble.
- `stall_cnt`, `flush_cnt`  out  16  performance counters (see Configuration).

## Operation
- Select encoding, matching the `mux_4` data ports:
  - 00: register file (`data0`).
  - 01: EX/MEM result (`data1`).
  - 10: MEM/WB result (`data2`).
  - 11: WB latch (`data3`).
- Per source, the next select is computed from the producers that will sit one, two and three stages ahead when the ID instruction reaches EX:
  - match `ex_rd` with `ex_reg_write` → 01;
  - else match `mem_rd` with `mem_reg_write` → 10;
  - else match `wb_rd` with `wb_reg_write` → 11;
  - else 00.
- Priority is 01 > 10 > 11 > 00, so the youngest producer wins.
- Register 0 is hardwired zero and never matches.
- Load-use condition: `id_valid & ex_mem_read & ex_reg_write & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- FSM states: RUN, STALL.
  - RUN, load-use detected, no branch: assert `stall_if`, `stall_id` and `flush_id_ex` this cycle. If `LOAD_LAT > 1`, load the counter with LOAD_LAT-1 and go to STALL; otherwise stay in RUN.
  - STALL: assert the same three signals and decrement the counter. Go to RUN when the counter reaches 1.
  - `branch_taken` in any state: assert `flush_if_id` and `flush_id_ex` and deassert both stalls. Go to RUN and clear the counter. A branch beats a load-use, because the stalled instruction is squashed.
- Select register update:
  - Loaded on every non-stall, non-flush cycle.
  - Loaded with 00 when `flush_id_ex` is asserted (the bubble).
  - When `stall_id` and `flush_id_ex` are both asserted, the bubble takes precedence and the register loads 00.
- After a 1-cycle load stall, the load sits in MEM, so the resumed instruction receives 10.

## Timing
- Reset (async assert, synchronous deassert by the caller): FSM = RUN, counter = 0.
- Every output resets to 0: `fwd_a_sel` = 00, `fwd_b_sel` = 00, both stalls, both flushes, and both counters.
- `fwd_*_sel` latency is 1 cycle: the value decided in ID appears in the cycle the instruction executes.
- Stall and flush outputs are combinational from the current inputs and FSM state, valid within the same cycle.
- Reset asserted mid-stall: the stall aborts immediately and no extra bubble is inserted.
- `id_valid = 0`: no load-use stall. Selects are still computed, but they are don't-care.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `stall_id` asserted.
  - `flush_cnt` increments on every cycle with `flush_if_id` asserted.
  - Both are 16-bit and saturate at 16'hFFFF.
- `HAZARD_PERF_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `cpu_pkg`:
  - `fwd_sel_t` (2-bit enum: `FWD_RF`, `FWD_EXMEM`, `FWD_MEMWB`, `FWD_WB`);
  - `hz_state_t` (`HZ_RUN`, `HZ_STALL`);
  - `REG_ZERO` constant.
- One sub-module `fwd_select`: the combinational priority match for a single source register, instantiated twice (operands A and B).

## Test plan
- Forwarding priority: `id_rs1 = 3`, `ex_rd = 3` (write), `mem_rd = 3` (write) → next cycle `fwd_a_sel` = 01. Repeat with only `mem_rd = 3` → 10; only `wb_rd = 3` → 11.
- R0 exclusion: `id_rs2 = 0`, `ex_rd = 0`, `ex_reg_write = 1` → `fwd_b_sel` = 00 and no stall.
- Load-use, `LOAD_LAT = 1`: load to r5 in EX, `id_rs1 = 5`:
  - cycle t: `stall_if` = `stall_id` = `flush_id_ex` = 1;
  - t+1: stalls = 0;
  - t+2: `fwd_a_sel` = 10.
- Load-use, `LOAD_LAT = 3`: stall held exactly 3 cycles; `stall_cnt` = 3 when `HAZARD_PERF_EN` is defined.
- Branch during a load stall (`LOAD_LAT = 3`, `branch_taken` in the 2nd stall cycle): both flushes = 1 and stalls = 0 that cycle; FSM = RUN next cycle; `fwd_*_sel` = 00.
- Reset mid-stall: `rst_n` low in the 2nd stall cycle → all outputs 0 immediately; after release, normal forwarding resumes from 00.
